// File: rtl/seg_msg_sched.sv
// seg_msg_sched: shares the seg7 x/dp inputs between a live background source
// and one-shot messages. A message can scroll in from the right one character
// per step, then holds for a fixed time, optionally blinking, before the
// background returns.
module seg_msg_sched #(
  parameter int SCROLL_CYC = 25_000_000,
  parameter int HOLD_CYC   = 100_000_000,
  parameter int BLINK_CYC  = 12_500_000
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [47:0] bg_x,
  input  logic [7:0]  bg_dp,
  input  logic        msg_req,
  input  logic [47:0] msg_x,
  input  logic [7:0]  msg_dp,
  input  logic        msg_scroll,
  input  logic        msg_blink,
  input  logic        msg_cancel,
  output logic        msg_ack,
  output logic        busy,
  output logic [47:0] x,
  output logic [7:0]  dp
);

  localparam int SW = (SCROLL_CYC > 1) ? $clog2(SCROLL_CYC) : 1;
  localparam int HW = (HOLD_CYC   > 1) ? $clog2(HOLD_CYC)   : 1;
  localparam int BW = (BLINK_CYC  > 1) ? $clog2(BLINK_CYC)  : 1;

  localparam logic [47:0] BLANK = '1;

  typedef enum logic [1:0] {IDLE, SCROLL, HOLD} state_t;

  state_t        state_q, state_d;
  logic [47:0]   x_q, x_d;
  logic [7:0]    dp_q, dp_d;
  logic          ack_q, ack_d;
  logic [47:0]   lx_q, lx_d;
  logic [7:0]    ldp_q, ldp_d;
  logic          lblink_q, lblink_d;
  logic [47:0]   srx_q, srx_d;
  logic [7:0]    srdp_q, srdp_d;
  logic [2:0]    shift_q, shift_d;
  logic [SW-1:0] step_q, step_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [BW-1:0] blink_q, blink_d;
  logic          phase_q, phase_d;

  // Register the whole scheduler state; clr returns to an idle, all-blank display.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= IDLE;
      x_q      <= BLANK;
      dp_q     <= '0;
      ack_q    <= 1'b0;
      lx_q     <= BLANK;
      ldp_q    <= '0;
      lblink_q <= 1'b0;
      srx_q    <= BLANK;
      srdp_q   <= '0;
      shift_q  <= '0;
      step_q   <= '0;
      hold_q   <= '0;
      blink_q  <= '0;
      phase_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      dp_q     <= dp_d;
      ack_q    <= ack_d;
      lx_q     <= lx_d;
      ldp_q    <= ldp_d;
      lblink_q <= lblink_d;
      srx_q    <= srx_d;
      srdp_q   <= srdp_d;
      shift_q  <= shift_d;
      step_q   <= step_d;
      hold_q   <= hold_d;
      blink_q  <= blink_d;
      phase_q  <= phase_d;
    end
  end

  // Next-state and next-display logic; timers default to zero so each state starts fresh.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    dp_d     = dp_q;
    ack_d    = 1'b0;
    lx_d     = lx_q;
    ldp_d    = ldp_q;
    lblink_d = lblink_q;
    srx_d    = srx_q;
    srdp_d   = srdp_q;
    shift_d  = shift_q;
    step_d   = '0;
    hold_d   = '0;
    blink_d  = '0;
    phase_d  = 1'b1;
    case (state_q)
      IDLE: begin
        x_d     = bg_x;
        dp_d    = bg_dp;
        shift_d = '0;
        if (msg_req) begin
          ack_d    = 1'b1;
          lx_d     = msg_x;
          ldp_d    = msg_dp;
          lblink_d = msg_blink;
          srx_d    = msg_x;
          srdp_d   = msg_dp;
          if (msg_scroll) begin
            state_d = SCROLL;
            x_d     = BLANK;
            dp_d    = '0;
          end else begin
            state_d = HOLD;
            x_d     = msg_x;
            dp_d    = msg_dp;
          end
        end
      end
      SCROLL: begin
        if (msg_cancel) begin
          state_d = IDLE;
          x_d     = bg_x;
          dp_d    = bg_dp;
        end else if (step_q == SW'(SCROLL_CYC - 1)) begin
          x_d     = {x_q[41:0], srx_q[47:42]};
          dp_d    = {dp_q[6:0], srdp_q[7]};
          srx_d   = {srx_q[41:0], 6'h3F};
          srdp_d  = {srdp_q[6:0], 1'b0};
          shift_d = shift_q + 3'd1;
          if (shift_q == 3'd7) begin
            state_d = HOLD;
          end
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      HOLD: begin
        if (msg_cancel || (hold_q == HW'(HOLD_CYC - 1))) begin
          state_d = IDLE;
          x_d     = bg_x;
          dp_d    = bg_dp;
        end else begin
          hold_d  = hold_q + 1'b1;
          phase_d = phase_q;
          if (blink_q == BW'(BLINK_CYC - 1)) begin
            if (lblink_q) begin
              phase_d = ~phase_q;
            end
          end else begin
            blink_d = blink_q + 1'b1;
          end
          x_d  = phase_d ? lx_q  : BLANK;
          dp_d = phase_d ? ldp_q : 8'h00;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign msg_ack = ack_q;
  assign busy    = (state_q != IDLE);
  assign x       = x_q;
  assign dp      = dp_q;

endmodule
